uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of uart_rx.
- Captures each received character on the uart_rx o_done strobe and stores it in a first-word-fall-through FIFO.
- Presents buffered characters to the bus/peripheral register interface with a read strobe.
- Flags overrun when characters arrive while the FIFO is full.

Parameters:
- DEPTH, 16, number of 9-bit entries; power of two, minimum 2.
- WIDTH, 9, character width; matches the uart_rx o_data width.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-low.
- i_data  input  WIDTH  received character; connects to uart_rx o_data.
- i_done  input  1  one-cycle strobe marking i_data valid; connects to uart_rx o_done.
- i_read  input  1  one-cycle pop strobe from the bus read of the RX data register.
- i_clr_overrun  input  1  clears the sticky overrun flag.
- o_data  output  WIDTH  head-of-FIFO character; 0 when empty.
- o_empty  output  1  FIFO holds no entries.
- o_full  output  1  FIFO holds DEPTH entries.
- o_count  output  $clog2(DEPTH)+1  number of stored entries.
- o_overrun  output  1  sticky; a character was dropped.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: i_rst=0 sampled on a rising i_clk edge resets the block. Reset values:
  - rd_ptr = 0, wr_ptr = 0, count = 0
  - o_empty = 1, o_full = 0, o_count = 0, o_overrun = 0, o_data = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all entries and wins over every other input in that cycle.
- Storage and pointers:
  - Memory is DEPTH x WIDTH.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is held in a separate register, so there is no pointer-compare ambiguity.
- Push: i_done=1 and (count<DEPTH, or a pop is accepted in the same cycle):
  - writes i_data to mem[wr_ptr]
  - wr_ptr += 1
- Pop: i_read=1 and count>0:
  - rd_ptr += 1
  - i_read while empty is ignored; no pointer change, no error flag.
- Count update:
  - +1 on push only, -1 on pop only, unchanged on push and pop together.
- Output timing:
  - o_data = mem[rd_ptr] combinationally when count>0, else 0 (first-word fall-through).
  - A character pushed on edge N is visible on o_data after edge N when the FIFO was empty (zero added latency).
- Flags:
  - o_empty = (count==0) and o_full = (count==DEPTH), both derived from the registered count.
- Full boundary:
  - i_done while full with no pop: the character is dropped, memory and pointers are unchanged, and o_overrun is set on that edge.
  - i_done and i_read together while full: both are accepted, count stays DEPTH, no overrun.
- Empty boundary:
  - i_done and i_read together while empty: the push is accepted and the pop is ignored; count becomes 1.
- Overrun flag:
  - Sticky until i_clr_overrun=1.
  - If a set condition and i_clr_overrun occur in the same cycle, set wins.
  - Overrun never alters stored data.
- Handshake:
  - Each i_done or i_read high cycle counts as one event; sources must pulse for one cycle.
  - Holding i_read high pops one entry per cycle until the FIFO is empty.

Optional Feature:
- Macro: UART_RX_FIFO_THRESHOLD_EN.
- Defined:
  - Adds input i_threshold, width $clog2(DEPTH)+1.
  - Adds output o_irq, a registered level: o_irq = (count >= i_threshold) && (i_threshold != 0), updated every cycle from the next-state count.
  - o_irq resets to 0.
- Undefined:
  - Neither port exists.
  - No threshold logic is synthesized.

Test Plan:
- Reset then idle: hold i_rst=0 for 2 cycles, then release -> o_empty=1, o_count=0, o_overrun=0, o_data=0.
- Single character: pulse i_done with i_data=9'h041 -> next cycle o_data=9'h041 and o_count=1; pulse i_read -> o_empty=1 and o_data=0.
- Fill and wrap: push 9'h100..9'h10F (DEPTH=16) -> o_full=1. Then alternate pop and push of 9'h1A0..9'h1AF for 40 cycles -> data pops in order across pointer wrap, with no overrun.
- Overrun: with the FIFO full, pulse i_done with 9'h0FF -> o_overrun=1, o_count=16, head still 9'h100. Then drive i_clr_overrun and i_done together while full -> o_overrun stays 1. Then i_clr_overrun alone -> o_overrun=0.
- Simultaneous events: while empty, assert i_done (9'h055) and i_read in the same cycle -> o_count=1, o_data=9'h055. While full, assert both -> o_count=16, the oldest entry is removed and 9'h055 is appended.
- With UART_RX_FIFO_THRESHOLD_EN defined and i_threshold=4: push 3 -> o_irq=0; push a 4th -> o_irq=1 the cycle after the push; pop 1 -> o_irq=0. Set i_threshold=0 -> o_irq stays 0 at any count.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer behind uart_rx with sticky overrun; UART_RX_FIFO_THRESHOLD_EN adds a threshold irq
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_done,
    input  logic                     i_read,
    input  logic                     i_clr_overrun,
`ifdef UART_RX_FIFO_THRESHOLD_EN
    input  logic [$clog2(DEPTH):0]   i_threshold,
    output logic                     o_irq,
`endif
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             push, pop;

    // a pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    always_comb begin
        pop       = i_read && (count_q != '0);
        push      = i_done && ((count_q != FULL) || pop);
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d   = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        overrun_d = (i_done && !push) ? 1'b1 : i_clr_overrun ? 1'b0 : overrun_q;
    end

    // pointer, count and flag registers; reset discards all entries
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // storage is not reset; writes only on an accepted push outside reset
    always_ff @(posedge i_clk) begin
        if (i_rst && push) mem_q[wr_ptr_q] <= i_data;
    end

`ifdef UART_RX_FIFO_THRESHOLD_EN
    logic irq_q, irq_d;

    // interrupt level computed from the next-state count so it tracks the count register
    always_comb begin
        irq_d = (count_d >= i_threshold) && (i_threshold != '0);
    end

    // registered interrupt level
    always_ff @(posedge i_clk) begin
        if (!i_rst) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign o_irq = irq_q;
`endif

    assign o_data    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == FULL);
    assign o_count   = count_q;
    assign o_overrun = overrun_q;
endmodule
